i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEVICE_ID, default 8'h11, value returned at control address 0.
REQ-002 Parameter DEVICE_TYPE, default 8'h9, low byte returned at control address 1.
REQ-003 Parameter TARGET_ADDRESS, default 7'h42, 7-bit I2C address this target answers to.
REQ-004 cpu_clock  input  1  sole clock; every flop is on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 write_enable  input  1  CPU write strobe.
REQ-007 is_control  input  1  CPU control-space select.
REQ-008 short_address  input  8  control address; bits [3:0] used.
REQ-009 cpu_data_in  input  16  CPU write data.
REQ-010 cpu_data_out  output  16  registered CPU read data.
REQ-011 SCL_in  input  1  I2C clock from the master's SCL_out, asynchronous.
REQ-012 SDA_in  input  1  I2C data line, asynchronous.
REQ-013 SDA_enable  output  1  1 = pull SDA low (open drain); 0 = release.

Function
REQ-014 SCL_in and SDA_in SHALL each pass a 2-flop synchronizer; edge detection SHALL use only synchronized values; operation is guaranteed for cpu_clock >= 8x SCL.
REQ-015 START = synchronized SDA falling while SCL high; STOP = synchronized SDA rising while SCL high; both SHALL be recognised in every state, including mid-byte.
REQ-016 SDA SHALL be sampled on SCL rise; SDA_enable SHALL change only on the cycle after an SCL fall is detected.
REQ-017 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-018 START (or repeated START) -> ADDR with bit counter 0; STOP -> IDLE from any state.
REQ-019 ADDR: shift 8 bits MSB first; if [7:1] == TARGET_ADDRESS -> ADDR_ACK, else -> IGNORE (SDA_enable stays 0 until START/STOP).
REQ-020 ACK: SDA_enable = 1 from the SCL fall after bit 8 until the SCL fall after bit 9.
REQ-021 After ADDR_ACK: R/W = 0 -> WR_DATA with first_byte = 1; R/W = 1 -> RD_DATA, loading reg[pointer].
REQ-022 WR_DATA with first_byte: byte[3:0] SHALL load pointer (bits [7:4] ignored), no register write; later bytes write reg[pointer], then pointer increments, wrapping 15 -> 0; every received byte is ACKed.
REQ-023 RD_DATA: drive SDA_enable = ~bit, MSB first, changing after each SCL fall; after bit 8 release SDA and increment pointer (wrapping), -> RD_ACK.
REQ-024 RD_ACK: master ACK (SDA low) -> RD_DATA with the next byte; NACK -> IGNORE until STOP/START.
REQ-025 rx_count and tx_count (8 bits each) SHALL count ACKed data bytes written and bytes transmitted, saturating at 255.
REQ-026 Control map, read: 0 {8'h0,DEVICE_ID}; 1 {flags,DEVICE_TYPE}; 2 {rx_count,tx_count}; 3 {8'h0,busy,addressed,2'b0,pointer}; 4..B {reg[2k],reg[2k+1]} with k = addr-4; others 16'h0.
REQ-027 Control write: 1 -> flags <= data[15:8]; 2 -> clear both counters; 4..B -> write two register bytes; other addresses ignored.
REQ-028 cpu_data_out SHALL be control_read one cycle after is_control, else 16'h0.
REQ-029 flags[0] = enable; while 0 the FSM SHALL be held in IDLE with SDA_enable = 0; clearing it mid-transaction aborts at once.
REQ-030 CPU write and I2C write to the same byte in one cycle: CPU wins, I2C byte dropped, still ACKed and counted.
REQ-031 busy = state != IDLE; addressed = state in {ADDR_ACK, WR_*, RD_*}.

Reset
REQ-032 reset_n low SHALL asynchronously set state IDLE, SDA_enable 0, cpu_data_out 0, flags 0, pointer 0, counters 0, all registers 0, synchronizers 1; reset mid-transfer releases SDA immediately.

Structure
REQ-033 Package i2c_pkg SHALL hold the state encoding and control-address constants shared with the I2C master device.
REQ-034 One sub-module, i2c_sync_edge: 2-flop synchronizer plus rise/fall detect, instantiated for SCL and SDA.

Verification
REQ-035 Enable; master writes addr 0x84, 0x03, 0xAA, 0xBB -> 3 ACKs on bytes 2-4, reg3 = AA, reg4 = BB, rx_count 2, pointer 5.
REQ-036 Pointer 0x0F, write 0x11, 0x22 -> reg15 = 11, reg0 = 22, pointer wraps to 1.
REQ-037 CPU writes addr 4 = 16'hCAFE; master writes 0x84, 0x00, repeated START, 0x85, reads 2 bytes ACK then NACK -> SDA carries CA, FE; tx_count 2; state IGNORE until STOP.
REQ-038 Address 0x90 -> no ACK, SDA_enable 0 throughout, registers unchanged, busy 1 until STOP.
REQ-039 Assert reset_n low mid-ACK -> SDA_enable 0 in the same cycle, status word 0 after release.
REQ-040 Clear flags[0] during RD_DATA -> SDA released next cycle, busy 0; same-cycle CPU/I2C write to reg4 -> CPU value retained.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared definitions for the I2C target and its master-side peer.
//   i2c_state_t : target protocol state encoding
//   CA_*        : control-space address map (short_address[3:0])
//   sat_inc     : 8-bit saturating increment used by the byte counters
//   is_reg_addr : true for control addresses that map onto register pairs
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } i2c_state_t;

    localparam logic [3:0] CA_ID        = 4'h0;
    localparam logic [3:0] CA_FLAGS     = 4'h1;
    localparam logic [3:0] CA_COUNT     = 4'h2;
    localparam logic [3:0] CA_STATUS    = 4'h3;
    localparam logic [3:0] CA_REG_FIRST = 4'h4;
    localparam logic [3:0] CA_REG_LAST  = 4'hB;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic is_reg_addr(input logic [3:0] a);
        return (a >= CA_REG_FIRST) && (a <= CA_REG_LAST);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge -- two-flop synchronizer for an asynchronous bus line, plus
// rise/fall detection on the synchronized value.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset; all flops reset to 1 (idle bus)
//   line  : asynchronous input
//   level : synchronized level
//   rise  : one-cycle pulse when level goes 0 -> 1
//   fall  : one-cycle pulse when level goes 1 -> 0
`timescale 1ns/1ps
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta   <= line;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev;
    assign fall  = ~sync_q & prev;

endmodule

// File: rtl/i2c_target.sv
// i2c_target -- I2C target with a 16-byte register file, exposed to a CPU
// through a small control space.
//   cpu_clock      : sole clock
//   reset_n        : asynchronous active-low reset
//   write_enable   : CPU write strobe (qualified by is_control)
//   is_control     : CPU control-space select
//   short_address  : control address, bits [3:0] decoded
//   cpu_data_in    : CPU write data
//   cpu_data_out   : registered control read data, 0 when not selected
//   SCL_in, SDA_in : asynchronous I2C bus lines
//   SDA_enable     : 1 pulls SDA low (open drain)
// Control map: 0 id, 1 {flags,type}, 2 {rx_count,tx_count},
// 3 {0,busy,addressed,00,pointer}, 4..B register pairs {reg[2k],reg[2k+1]}.
`timescale 1ns/1ps
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID      = 8'h11,
    parameter logic [7:0] DEVICE_TYPE    = 8'h09,
    parameter logic [6:0] TARGET_ADDRESS = 7'h42
) (
    input  logic        cpu_clock,
    input  logic        reset_n,
    input  logic        write_enable,
    input  logic        is_control,
    input  logic [7:0]  short_address,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    input  logic        SCL_in,
    input  logic        SDA_in,
    output logic        SDA_enable
);

    // ---------------------------------------------------------------
    // Bus line synchronizers and START/STOP detection
    // ---------------------------------------------------------------
    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .clk   (cpu_clock),
        .rst_n (reset_n),
        .line  (SCL_in),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk   (cpu_clock),
        .rst_n (reset_n),
        .line  (SDA_in),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;

    // ---------------------------------------------------------------
    // Storage shared between the FSM and the CPU port
    // ---------------------------------------------------------------
    logic [7:0] regs [16];
    logic [7:0] flags;
    logic [7:0] rx_count;
    logic [7:0] tx_count;
    logic       enable;

    assign enable = flags[0];

    // ---------------------------------------------------------------
    // Protocol FSM
    // ---------------------------------------------------------------
    i2c_state_t state;
    logic [3:0] bit_cnt;     // SCL rises seen in the current byte
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [3:0] pointer;
    logic       first_byte;  // next write byte sets the pointer
    logic       rw;
    logic       master_ack;

    // Register-file write request raised by the FSM, applied one cycle
    // later in the storage block where the CPU port can override it.
    logic       i2c_wr;
    logic [3:0] i2c_wr_idx;
    logic [7:0] i2c_wr_byte;
    logic       rx_inc;
    logic       tx_inc;

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            bit_cnt     <= 4'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            pointer     <= 4'd0;
            first_byte  <= 1'b0;
            rw          <= 1'b0;
            master_ack  <= 1'b0;
            SDA_enable  <= 1'b0;
            i2c_wr      <= 1'b0;
            i2c_wr_idx  <= 4'd0;
            i2c_wr_byte <= 8'h00;
            rx_inc      <= 1'b0;
            tx_inc      <= 1'b0;
        end else begin
            i2c_wr <= 1'b0;
            rx_inc <= 1'b0;
            tx_inc <= 1'b0;

            if (!enable) begin
                state      <= S_IDLE;
                bit_cnt    <= 4'd0;
                SDA_enable <= 1'b0;
            end else if (stop_det) begin
                state      <= S_IDLE;
                SDA_enable <= 1'b0;
            end else if (start_det) begin
                state      <= S_ADDR;
                bit_cnt    <= 4'd0;
                SDA_enable <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: ;

                    S_ADDR: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[6:0], sda_level};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (rx_shift[7:1] == TARGET_ADDRESS) begin
                                state      <= S_ADDR_ACK;
                                rw         <= rx_shift[0];
                                SDA_enable <= 1'b1;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                    end

                    // Entered on the fall after bit 8, so the next fall
                    // closes the ACK clock.
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state      <= S_RD_DATA;
                                tx_shift   <= regs[pointer];
                                SDA_enable <= ~regs[pointer][7];
                            end else begin
                                state      <= S_WR_DATA;
                                first_byte <= 1'b1;
                                SDA_enable <= 1'b0;
                            end
                        end
                    end

                    S_WR_DATA: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[6:0], sda_level};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state      <= S_WR_ACK;
                            bit_cnt    <= 4'd0;
                            SDA_enable <= 1'b1;
                            if (first_byte) begin
                                pointer    <= rx_shift[3:0];
                                first_byte <= 1'b0;
                            end else begin
                                i2c_wr      <= 1'b1;
                                i2c_wr_idx  <= pointer;
                                i2c_wr_byte <= rx_shift;
                                rx_inc      <= 1'b1;
                                pointer     <= pointer + 4'd1;
                            end
                        end
                    end

                    S_WR_ACK: begin
                        if (scl_fall) begin
                            state      <= S_WR_DATA;
                            bit_cnt    <= 4'd0;
                            SDA_enable <= 1'b0;
                        end
                    end

                    // Bit 7 is already on the line at entry; each later fall
                    // presents the next bit until all 8 have been clocked.
                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state      <= S_RD_ACK;
                            bit_cnt    <= 4'd0;
                            SDA_enable <= 1'b0;
                            pointer    <= pointer + 4'd1;
                            tx_inc     <= 1'b1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            tx_shift   <= {tx_shift[6:0], 1'b0};
                            SDA_enable <= ~tx_shift[6];
                        end
                    end

                    S_RD_ACK: begin
                        if (scl_rise) begin
                            master_ack <= ~sda_level;
                        end else if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (master_ack) begin
                                state      <= S_RD_DATA;
                                tx_shift   <= regs[pointer];
                                SDA_enable <= ~regs[pointer][7];
                            end else begin
                                state      <= S_IGNORE;
                                SDA_enable <= 1'b0;
                            end
                        end
                    end

                    S_IGNORE: ;

                    default: begin
                        state      <= S_IDLE;
                        SDA_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic busy, addressed;
    assign busy      = (state != S_IDLE);
    assign addressed = (state == S_ADDR_ACK) || (state == S_WR_DATA) ||
                       (state == S_WR_ACK)   || (state == S_RD_DATA) ||
                       (state == S_RD_ACK);

    // ---------------------------------------------------------------
    // CPU control space
    // ---------------------------------------------------------------
    logic [3:0] caddr;
    logic [2:0] reg_pair;
    logic [3:0] idx_hi, idx_lo;
    logic       cpu_wr;
    logic       addr_unused;

    assign caddr       = short_address[3:0];
    assign addr_unused = &short_address[7:4];
    assign reg_pair    = 3'(caddr - CA_REG_FIRST);
    assign idx_hi      = {reg_pair, 1'b0};
    assign idx_lo      = {reg_pair, 1'b1};
    assign cpu_wr      = write_enable & is_control;

    logic [15:0] control_read;

    always_comb begin
        control_read = 16'h0000;
        case (caddr)
            CA_ID:     control_read = {8'h00, DEVICE_ID};
            CA_FLAGS:  control_read = {flags, DEVICE_TYPE};
            CA_COUNT:  control_read = {rx_count, tx_count};
            CA_STATUS: control_read = {8'h00, busy, addressed, 2'b00, pointer};
            default: begin
                if (is_reg_addr(caddr))
                    control_read = {regs[idx_hi], regs[idx_lo]};
            end
        endcase
    end

    // The CPU write is applied after the I2C write so that it wins a
    // same-cycle collision; the I2C byte is still counted.
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
            flags        <= 8'h00;
            rx_count     <= 8'h00;
            tx_count     <= 8'h00;
            cpu_data_out <= 16'h0000;
        end else begin
            if (i2c_wr) regs[i2c_wr_idx] <= i2c_wr_byte;
            if (rx_inc) rx_count <= sat_inc(rx_count);
            if (tx_inc) tx_count <= sat_inc(tx_count);

            if (cpu_wr) begin
                if (caddr == CA_FLAGS) begin
                    flags <= cpu_data_in[15:8];
                end else if (caddr == CA_COUNT) begin
                    rx_count <= 8'h00;
                    tx_count <= 8'h00;
                end else if (is_reg_addr(caddr)) begin
                    regs[idx_hi] <= cpu_data_in[15:8];
                    regs[idx_lo] <= cpu_data_in[7:0];
                end
            end

            cpu_data_out <= is_control ? control_read : 16'h0000;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int         Q     = 80;      // quarter of an SCL bit period
    localparam logic [6:0] TADDR = 7'h42;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        is_ctl = 1'b0;
    logic [7:0]  sa = 8'h00;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_en;
    logic        sda_line;

    assign sda_line = m_sda & ~sda_en;   // open-drain wired AND

    i2c_target dut (
        .cpu_clock     (clk),
        .reset_n       (rst_n),
        .write_enable  (we),
        .is_control    (is_ctl),
        .short_address (sa),
        .cpu_data_in   (din),
        .cpu_data_out  (dout),
        .SCL_in        (scl),
        .SDA_in        (sda_line),
        .SDA_enable    (sda_en)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_regs [16];
    logic [3:0] m_ptr;
    logic [7:0] m_rx, m_tx, m_flags;

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'd255) ? v : v + 8'd1;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0; m_rx = 8'd0; m_tx = 8'd0; m_flags = 8'h00;
    endtask

    task automatic mdl_wr_byte(input logic [7:0] b);
        m_regs[m_ptr] = b;
        m_ptr = m_ptr + 4'd1;
        m_rx = sat(m_rx);
    endtask

    task automatic mdl_rd_byte(output logic [7:0] b);
        b = m_regs[m_ptr];
        m_ptr = m_ptr + 4'd1;
        m_tx = sat(m_tx);
    endtask

    task automatic mdl_cpu_write(input logic [3:0] a, input logic [15:0] v);
        int k;
        if (a == 4'd1) m_flags = v[15:8];
        else if (a == 4'd2) begin m_rx = 8'd0; m_tx = 8'd0; end
        else if (a >= 4'd4 && a <= 4'd11) begin
            k = 2 * (int'(a) - 4);
            m_regs[k]   = v[15:8];
            m_regs[k+1] = v[7:0];
        end
    endtask

    // ---------------- CPU port ----------------
    task automatic cpu_write(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk); is_ctl = 1'b1; we = 1'b1; sa = {4'h0, a}; din = v;
        @(negedge clk); is_ctl = 1'b0; we = 1'b0;
        mdl_cpu_write(a, v);
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk); is_ctl = 1'b1; we = 1'b0; sa = {4'h0, a};
        @(negedge clk); d = dout; is_ctl = 1'b0;
    endtask

    task automatic cmp_all(input string tag);
        logic [15:0] d;
        for (int k = 0; k < 8; k++) begin
            cpu_read(4'(4 + k), d);
            chk($sformatf("%s_pair%0d", tag, k), d, {m_regs[2*k], m_regs[2*k+1]});
        end
        cpu_read(4'd2, d); chk({tag, "_count"}, d, {m_rx, m_tx});
        cpu_read(4'd3, d); chk({tag, "_status"}, d, {12'h000, m_ptr});
        cpu_read(4'd1, d); chk({tag, "_flags"}, d, {m_flags, 8'h09});
    endtask

    // ---------------- I2C master ----------------
    task automatic bus_start();
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(x);
        ack = ~x;
    endtask

    task automatic read_byte(input logic ack_it, output logic [7:0] b);
        logic x;
        for (int i = 7; i >= 0; i--) begin recv_bit(x); b[i] = x; end
        send_bit(ack_it ? 1'b0 : 1'b1);
    endtask

    // Pointer byte then n data bytes (data[7:0] sent first).
    task automatic txn_write(input logic [3:0] ptr, input int n, input logic [31:0] data);
        logic a;
        bus_start();
        write_byte({TADDR, 1'b0}, a); chk("wr_addr_ack", 16'(a), 16'd1);
        write_byte({4'h0, ptr}, a);   chk("wr_ptr_ack", 16'(a), 16'd1);
        m_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            write_byte(data[8*i +: 8], a);
            chk($sformatf("wr_data%0d_ack", i), 16'(a), 16'd1);
            mdl_wr_byte(data[8*i +: 8]);
        end
        bus_stop();
    endtask

    // Set pointer, repeated START, read n bytes (last one NACKed); no STOP.
    task automatic txn_read(input logic [3:0] ptr, input int n, output logic [31:0] got);
        logic a;
        logic [7:0] b, e;
        got = 32'h0;
        bus_start();
        write_byte({TADDR, 1'b0}, a); chk("rd_waddr_ack", 16'(a), 16'd1);
        write_byte({4'h0, ptr}, a);   chk("rd_ptr_ack", 16'(a), 16'd1);
        m_ptr = ptr;
        bus_start();
        write_byte({TADDR, 1'b1}, a); chk("rd_raddr_ack", 16'(a), 16'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, b);
            mdl_rd_byte(e);
            chk($sformatf("rd_byte%0d", i), 16'(b), 16'(e));
            got[8*i +: 8] = b;
        end
    endtask

    // Counts cycles where SDA is pulled while the watch window is open.
    logic watch = 1'b0;
    int   en_seen = 0;
    always @(posedge clk) if (watch && sda_en) en_seen++;

    // Shared between the fork branches of the collision scenario.
    logic c_a1, c_a2, c_a3;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic [31:0] rd;
        logic        a;
        logic        seen;

        mdl_reset();
        repeat (3) @(negedge clk);
        chk("rst_sda_en", 16'(sda_en), 16'd0);
        chk("rst_dout", dout, 16'h0000);
        rst_n = 1'b1;

        // Reset state of the control space
        cpu_read(4'd0, d); chk("id", d, 16'h0011);
        cpu_read(4'd1, d); chk("type_flags", d, 16'h0009);
        cpu_read(4'd2, d); chk("counts0", d, 16'h0000);
        cpu_read(4'd3, d); chk("status0", d, 16'h0000);
        @(negedge clk);    chk("dout_unselected", dout, 16'h0000);

        cpu_write(4'd1, 16'h0100);
        cpu_read(4'd1, d); chk("flags_en", d, 16'h0109);

        // Pointer 3, write AA BB
        txn_write(4'd3, 2, 32'h0000_BBAA);
        cpu_read(4'd5, d); chk("reg3", 16'(d[7:0]), 16'h00AA);
        cpu_read(4'd6, d); chk("reg4", 16'(d[15:8]), 16'h00BB);
        cpu_read(4'd2, d); chk("rx2", 16'(d[15:8]), 16'd2);
        cpu_read(4'd3, d); chk("ptr5", d, 16'h0005);

        // Pointer wrap 15 -> 0
        txn_write(4'd15, 2, 32'h0000_2211);
        cpu_read(4'd11, d); chk("reg15", 16'(d[7:0]), 16'h0011);
        cpu_read(4'd4, d);  chk("reg0", 16'(d[15:8]), 16'h0022);
        cpu_read(4'd3, d);  chk("ptr_wrap", d, 16'h0001);

        // Read CA FE, ACK then NACK; target ignores until STOP
        cpu_write(4'd4, 16'hCAFE);
        txn_read(4'd0, 2, rd);
        chk("rd_CA", 16'(rd[7:0]), 16'h00CA);
        chk("rd_FE", 16'(rd[15:8]), 16'h00FE);
        cpu_read(4'd2, d); chk("tx2", 16'(d[7:0]), 16'd2);
        cpu_read(4'd3, d); chk("ignore_status", d, {8'h00, 1'b1, 1'b0, 2'b00, m_ptr});
        bus_stop();
        cpu_read(4'd3, d); chk("after_stop", d, {12'h000, m_ptr});

        // Foreign address 0x90: no ACK, SDA never pulled, busy until STOP
        en_seen = 0; watch = 1'b1;
        bus_start();
        write_byte(8'h90, a); chk("foreign_ack", 16'(a), 16'd0);
        write_byte(8'h5A, a); chk("foreign_data_ack", 16'(a), 16'd0);
        cpu_read(4'd3, d); chk("foreign_busy", d, {8'h00, 1'b1, 1'b0, 2'b00, m_ptr});
        bus_stop();
        watch = 1'b0;
        chk("foreign_sda_quiet", 16'(en_seen), 16'd0);
        cmp_all("foreign");

        // Randomized transactions against the model
        for (int it = 0; it < 10; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            case (op)
                0: txn_write(4'($urandom_range(0, 15)), int'($urandom_range(1, 4)), $urandom);
                1: begin
                    txn_read(4'($urandom_range(0, 15)), int'($urandom_range(1, 3)), rd);
                    bus_stop();
                end
                2: begin
                    logic [6:0] fa;
                    logic       frw;
                    fa  = 7'($urandom_range(0, 127));
                    if (fa == TADDR) fa = fa ^ 7'h01;
                    frw = 1'($urandom_range(0, 1));
                    bus_start();
                    write_byte({fa, frw}, a);
                    chk("rand_foreign_ack", 16'(a), 16'(fa == TADDR));
                    bus_stop();
                end
                default: begin
                    logic [3:0] ca;
                    ca = 4'($urandom_range(0, 15));
                    if (ca == 4'd1) ca = 4'd4;
                    cpu_write(ca, 16'($urandom));
                end
            endcase
            cmp_all($sformatf("rand%0d", it));
        end

        // Reset asserted during an address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(8'h84 >> i);
        seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            seen = sda_en;
        end
        chk("ack_before_reset", 16'(seen), 16'd1);
        #2 rst_n = 1'b0;
        #1 chk("reset_releases_sda", 16'(sda_en), 16'd0);
        scl = 1'b1; m_sda = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        cpu_read(4'd3, d); chk("status_after_reset", d, 16'h0000);
        cmp_all("post_reset");
        cpu_write(4'd1, 16'h0100);

        // Disable during RD_DATA
        cpu_write(4'd4, 16'h0000);
        bus_start();
        write_byte({TADDR, 1'b0}, a); chk("abort_waddr_ack", 16'(a), 16'd1);
        write_byte(8'h00, a);         chk("abort_ptr_ack", 16'(a), 16'd1);
        m_ptr = 4'd0;
        bus_start();
        write_byte({TADDR, 1'b1}, a); chk("abort_raddr_ack", 16'(a), 16'd1);
        for (int i = 0; i < 3; i++) recv_bit(a);
        chk("abort_driving", 16'(sda_en), 16'd1);
        cpu_write(4'd1, 16'h0000);
        @(negedge clk);
        chk("abort_sda_released", 16'(sda_en), 16'd0);
        cpu_read(4'd3, d); chk("abort_idle", d, {12'h000, m_ptr});
        bus_stop();
        cpu_write(4'd1, 16'h0100);

        // CPU and I2C write reg4 together: CPU value retained
        fork
            begin
                bus_start();
                write_byte({TADDR, 1'b0}, c_a1);
                write_byte(8'h04, c_a2);
                write_byte(8'h5A, c_a3);
                bus_stop();
            end
            begin
                logic got_ack;
                got_ack = 1'b0;
                #(100*Q);
                @(negedge clk); is_ctl = 1'b1; we = 1'b1; sa = 8'h06; din = 16'h1357;
                for (int c = 0; c < 600 && !got_ack; c++) begin
                    @(negedge clk);
                    got_ack = sda_en;
                end
                repeat (2) @(negedge clk);
                is_ctl = 1'b0; we = 1'b0;
                chk("collide_ack_seen", 16'(got_ack), 16'd1);
            end
        join
        chk("collide_ack1", 16'(c_a1), 16'd1);
        chk("collide_ack2", 16'(c_a2), 16'd1);
        chk("collide_ack3", 16'(c_a3), 16'd1);
        m_ptr = 4'd4;
        mdl_wr_byte(8'h5A);
        mdl_cpu_write(4'd6, 16'h1357);
        cpu_read(4'd6, d); chk("collide_cpu_wins", d, 16'h1357);
        cmp_all("collide");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
